// File: rtl/flash_rd_arb.sv
// Two-requester arbiter for the shared flash read port with an in-order owner-ID FIFO.
// Optional FLASH_RD_ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins) instead of round-robin.
module flash_rd_arb #(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned AW             = 12,
  parameter int unsigned BKW            = 1,
  parameter int unsigned DW             = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [2*AW-1:0]   addr_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DW-1:0]     rdata_o,
  output logic              flash_req_o,
  output logic [BKW-1:0]    flash_bank_o,
  output logic [AW-BKW-1:0] flash_addr_o,
  input  logic              flash_gnt_i,
  input  logic              flash_rvalid_i,
  input  logic [DW-1:0]     flash_rdata_i,
  output logic              unexp_rsp_o
);

  localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CW = $clog2(NumOutstanding + 1);

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          owner_q [NumOutstanding];

  logic          full;
  logic          win;
  logic          accept;
  logic          pop;
  logic [AW-1:0] win_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NumOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef FLASH_RD_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when fetch is idle.
  always_comb begin
    win = req_i[1] & ~req_i[0];
  end
`else
  logic prio;

  // prio holds the requester that was not granted last.
  always_comb begin
    win = (&req_i) ? prio : req_i[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~win;
    end
  end
`endif

  // Request path: arbitration, address split and grant.
  always_comb begin
    full         = (count == CW'(NumOutstanding));
    flash_req_o  = (|req_i) & ~full;
    accept       = flash_req_o & flash_gnt_i;
    win_addr     = win ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
    flash_bank_o = '0;
    flash_addr_o = '0;
    if (flash_req_o) begin
      flash_bank_o = win_addr[AW-1 -: BKW];
      flash_addr_o = win_addr[AW-BKW-1:0];
    end
    gnt_o        = '0;
    gnt_o[win]   = accept;
  end

  // Response path: route in-order data to the oldest owner.
  always_comb begin
    pop                    = flash_rvalid_i & (count != '0);
    unexp_rsp_o            = flash_rvalid_i & (count == '0);
    rvalid_o               = '0;
    rvalid_o[owner_q[rd_ptr]] = pop;
    rdata_o                = pop ? flash_rdata_i : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < NumOutstanding; i++) begin
        owner_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= win;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
